// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: funct3 codes,
// access sizes, FSM states and the byte-enable / alignment rules.
package mem_stage_lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    localparam logic [31:0] LSU_NOP = 32'h0000_0013;

    // Unlisted load encodings fall back to a full word access.
    function automatic lsu_size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic lsu_size_e store_size(input logic [2:0] f3);
        case (f3)
            F3_B:    return SZ_B;
            F3_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] size_be(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Word-addressed req/ack data bus between the MEM stage (master) and memory (slave).
interface mem_stage_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load lane extraction with sign or zero extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Replicating the data lets memory pick it up on whichever lane the enables select.
    always_comb begin
        be_o = size_be(size_i, off_i);
        case (size_i)
            SZ_B:    wdata_o = {4{wdata_i[7:0]}};
            SZ_H:    wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        case (off_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (size_i)
            SZ_B:    rdata_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
            SZ_H:    rdata_o = {{16{sign_i & half_lane[15]}}, half_lane};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: drives loads/stores onto the req/ack bus, stalls upstream while
// an access is outstanding, aborts stuck accesses and owns the MEM/WB register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = LSU_NOP,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_wr_mem_mem,
    input  logic                  mem_wr_mem,
    input  logic                  reg_wr_mem,
    input  logic [1:0]            wb_sel_mem,
    input  logic [31:0]           addr_mem,
    input  logic [31:0]           wdata_mem,
    input  logic [31:0]           Inst_mem,
    input  logic [31:0]           PC_mem,
    mem_stage_lsu_if.master       dbus,
    output logic                  stall_mem,
    output logic                  misalign_exc,
    output logic                  bus_err_exc,
    output logic                  reg_wr_wb,
    output logic [1:0]            wb_sel_wb,
    output logic [31:0]           alu_wb,
    output logic [31:0]           rdata_wb,
    output logic [31:0]           Inst_wb,
    output logic [31:0]           PC_wb
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [2:0]       funct3;
    logic             is_store;
    logic             is_load;
    logic             memop;
    lsu_size_e        size;
    logic             misal_drop;
    logic             access;
    logic             acked;
    logic             abort;
    logic [3:0]       be_lane;
    logic [31:0]      wdata_lane;
    logic [31:0]      ld_ext;
    logic [31:0]      rdata_d;

    lsu_state_t       state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             reg_wr_q;
    logic [1:0]       wb_sel_q;
    logic [31:0]      alu_q;
    logic [31:0]      rdata_q;
    logic [31:0]      inst_q;
    logic [31:0]      pc_q;
    logic             mis_exc_q;
    logic             bus_err_q;

    assign funct3   = Inst_mem[14:12];
    assign is_store = mem_wr_mem;
    assign is_load  = rd_wr_mem_mem & ~mem_wr_mem;
    assign memop    = rd_wr_mem_mem | mem_wr_mem;
    assign size     = is_store ? store_size(funct3) : load_size(funct3);

    // EX/MEM is frozen while stalled, so WAIT keeps reissuing the same access.
    assign misal_drop = (state_q == IDLE) & memop & is_misaligned(size, addr_mem[1:0]);
    assign access     = (state_q == WAIT) | (memop & ~misal_drop);
    assign acked      = access & dbus.ack;
    assign abort      = (state_q == WAIT) & ~dbus.ack & (wait_cnt_q == CNT_W'(MAX_WAIT));
    assign stall_mem  = access & ~dbus.ack & ~abort;

    mem_stage_lsu_align u_align (
        .size_i  (size),
        .sign_i  (~funct3[2]),
        .off_i   (addr_mem[1:0]),
        .wdata_i (wdata_mem),
        .rdata_i (dbus.rdata),
        .be_o    (be_lane),
        .wdata_o (wdata_lane),
        .rdata_o (ld_ext)
    );

    assign dbus.req   = access;
    assign dbus.we    = is_store;
    assign dbus.addr  = {addr_mem[31:2], 2'b00};
    assign dbus.be    = be_lane;
    assign dbus.wdata = wdata_lane;

    assign rdata_d = (acked & is_load) ? ld_ext : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            reg_wr_q   <= 1'b0;
            wb_sel_q   <= 2'b00;
            alu_q      <= 32'h0;
            rdata_q    <= 32'h0;
            inst_q     <= NOP_INST;
            pc_q       <= 32'h0;
            mis_exc_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            mis_exc_q <= misal_drop;
            bus_err_q <= abort;

            case (state_q)
                IDLE: begin
                    if (access && !dbus.ack) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dbus.ack || abort) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                end
            endcase

            // Stalled, aborted and dropped accesses all retire as a bubble.
            if (acked || !(access || misal_drop)) begin
                reg_wr_q <= reg_wr_mem;
                wb_sel_q <= wb_sel_mem;
                alu_q    <= addr_mem;
                rdata_q  <= rdata_d;
                inst_q   <= Inst_mem;
                pc_q     <= PC_mem;
            end else begin
                reg_wr_q <= 1'b0;
                wb_sel_q <= 2'b00;
                alu_q    <= 32'h0;
                rdata_q  <= 32'h0;
                inst_q   <= NOP_INST;
                pc_q     <= 32'h0;
            end
        end
    end

    assign misalign_exc = mis_exc_q;
    assign bus_err_exc  = bus_err_q;
    assign reg_wr_wb    = reg_wr_q;
    assign wb_sel_wb    = wb_sel_q;
    assign alu_wb       = alu_q;
    assign rdata_wb     = rdata_q;
    assign Inst_wb      = inst_q;
    assign PC_wb        = pc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, reset-in-WAIT sequence and
// randomized transactions checked against a size/offset arithmetic model.
module tb_mem_stage_lsu;

    localparam int          MW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld, st, rw;
    logic [1:0]  wbsel;
    logic [31:0] addr, wdata, inst, pc;
    logic        stall, mexc, bexc, rw_wb;
    logic [1:0]  wbsel_wb;
    logic [31:0] alu_wb, rd_wb, inst_wb, pc_wb;

    always #5 clk = ~clk;

    mem_stage_lsu_if dbus_if ();

    mem_stage_lsu #(.NOP_INST(NOP), .MAX_WAIT(MW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_wr_mem_mem (ld),
        .mem_wr_mem    (st),
        .reg_wr_mem    (rw),
        .wb_sel_mem    (wbsel),
        .addr_mem      (addr),
        .wdata_mem     (wdata),
        .Inst_mem      (inst),
        .PC_mem        (pc),
        .dbus          (dbus_if),
        .stall_mem     (stall),
        .misalign_exc  (mexc),
        .bus_err_exc   (bexc),
        .reg_wr_wb     (rw_wb),
        .wb_sel_wb     (wbsel_wb),
        .alu_wb        (alu_wb),
        .rdata_wb      (rd_wb),
        .Inst_wb       (inst_wb),
        .PC_wb         (pc_wb)
    );

    typedef struct {
        logic        ld, st, rw;
        logic [1:0]  wbsel;
        logic [31:0] inst, addr, wdata, pc, rdata;
        int          dly;
    } txn_t;

    typedef struct {
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata, rdwb;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          sz, off;
        logic [2:0]  f3;
        logic [31:0] mask, v;
        f3  = t.inst[14:12];
        off = int'(t.addr[1:0]);
        if (t.st) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else      sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        e.mis   = (t.ld || t.st) && (off % sz != 0);
        e.be    = (sz == 1) ? 4'(1 << off) : (sz == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
        e.wdata = (sz == 1) ? (t.wdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (t.wdata & 32'hFFFF) * 32'h0001_0001 : t.wdata;
        e.rdwb  = 32'h0;
        if (t.ld && !t.st) begin
            if (sz == 4) e.rdwb = t.rdata;
            else begin
                mask = (sz == 1) ? 32'hFF : 32'hFFFF;
                v = (t.rdata >> (8 * ((sz == 1) ? off : (off & 2)))) & mask;
                if (!f3[2] && v > (mask >> 1)) v = v | ~mask;
                e.rdwb = v;
            end
        end
        return e;
    endfunction

    task automatic run(input txn_t t, input exp_t e, input string tag);
        logic memop, req, fin, wrote;
        int   n;
        memop = t.ld | t.st;
        req   = memop && !e.mis;
        if (!req) n = 1;
        else if (t.dly <= MW) n = t.dly + 1;
        else n = MW + 1;
        ld = t.ld; st = t.st; rw = t.rw; wbsel = t.wbsel;
        inst = t.inst; addr = t.addr; wdata = t.wdata; pc = t.pc;
        dbus_if.rdata = t.rdata;
        for (int k = 0; k < n; k++) begin
            dbus_if.ack = (k == t.dly);
            #1;
            chk(tag, "req", 32'(dbus_if.req), 32'(req));
            chk(tag, "stall", 32'(stall), 32'(req && k < t.dly && k < MW));
            if (req) begin
                chk(tag, "addr", dbus_if.addr, {t.addr[31:2], 2'b00});
                chk(tag, "be", 32'(dbus_if.be), 32'(e.be));
                chk(tag, "we", 32'(dbus_if.we), 32'(t.st));
                if (t.st) chk(tag, "wdata", dbus_if.wdata, e.wdata);
            end
            @(posedge clk); #1;
            fin   = (k == n - 1);
            wrote = fin && (!memop || (req && t.dly <= MW));
            chk(tag, "misalign_exc", 32'(mexc), 32'(fin && e.mis));
            chk(tag, "bus_err_exc", 32'(bexc), 32'(fin && req && t.dly > MW));
            if (wrote) begin
                chk(tag, "reg_wr_wb", 32'(rw_wb), 32'(t.rw));
                chk(tag, "wb_sel_wb", 32'(wbsel_wb), 32'(t.wbsel));
                chk(tag, "alu_wb", alu_wb, t.addr);
                chk(tag, "rdata_wb", rd_wb, e.rdwb);
                chk(tag, "Inst_wb", inst_wb, t.inst);
                chk(tag, "PC_wb", pc_wb, t.pc);
            end else begin
                chk(tag, "bubble reg_wr_wb", 32'(rw_wb), 32'h0);
                chk(tag, "bubble Inst_wb", inst_wb, NOP);
            end
        end
        dbus_if.ack = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, "req", 32'(dbus_if.req), 32'h0);
        chk(tag, "stall", 32'(stall), 32'h0);
        chk(tag, "misalign_exc", 32'(mexc), 32'h0);
        chk(tag, "bus_err_exc", 32'(bexc), 32'h0);
        chk(tag, "reg_wr_wb", 32'(rw_wb), 32'h0);
        chk(tag, "wb_sel_wb", 32'(wbsel_wb), 32'h0);
        chk(tag, "alu_wb", alu_wb, 32'h0);
        chk(tag, "rdata_wb", rd_wb, 32'h0);
        chk(tag, "Inst_wb", inst_wb, NOP);
        chk(tag, "PC_wb", pc_wb, 32'h0);
    endtask

    function automatic vec_t mk(input logic l, input logic s, input logic r, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input int d, input logic mis, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v.t.ld = l; v.t.st = s; v.t.rw = r; v.t.wbsel = 2'b01;
        v.t.inst = {17'h0, f3, 12'h2A3};
        v.t.addr = a; v.t.wdata = wd; v.t.rdata = rd; v.t.pc = 32'h0; v.t.dly = d;
        v.e.mis = mis; v.e.be = be; v.e.wdata = ewd; v.e.rdwb = erd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[14];
        txn_t        t;
        logic [31:0] r;

        vecs[0]  = mk(0, 1, 0, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(1, 0, 1, 3'd0, 32'h203, 32'h0,        32'h80123456, 3, 0, 4'h8, 32'h0,        32'hFFFFFF80);
        vecs[2]  = mk(1, 0, 1, 3'd5, 32'h202, 32'h0,        32'hBEEF1234, 1, 0, 4'hC, 32'h0,        32'h0000BEEF);
        vecs[3]  = mk(0, 1, 1, 3'd1, 32'h202, 32'h000055AA, 32'h0,        0, 0, 4'hC, 32'h55AA55AA, 32'h0);
        vecs[4]  = mk(1, 0, 1, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1, 4'hF, 32'h0,        32'h0);
        vecs[5]  = mk(1, 0, 1, 3'd2, 32'h300, 32'h0,        32'h0,        9, 0, 4'hF, 32'h0,        32'h0);
        vecs[6]  = mk(0, 0, 1, 3'd0, 32'h12345678, 32'h0,   32'h0,        0, 0, 4'h1, 32'h0,        32'h0);
        vecs[7]  = mk(1, 0, 1, 3'd1, 32'h202, 32'h0,        32'h80011234, 2, 0, 4'hC, 32'h0,        32'hFFFF8001);
        vecs[8]  = mk(1, 0, 1, 3'd4, 32'h201, 32'h0,        32'h0000A500, 0, 0, 4'h2, 32'h0,        32'h000000A5);
        vecs[9]  = mk(1, 1, 0, 3'd0, 32'h001, 32'h00000077, 32'hFFFFFFFF, 0, 0, 4'h2, 32'h77777777, 32'h0);
        vecs[10] = mk(1, 0, 1, 3'd1, 32'h203, 32'h0,        32'h0,        1, 1, 4'hC, 32'h0,        32'h0);
        vecs[11] = mk(1, 0, 1, 3'd2, 32'h208, 32'h0,        32'hCAFEF00D, 4, 0, 4'hF, 32'h0,        32'hCAFEF00D);
        vecs[12] = mk(1, 0, 1, 3'd3, 32'h20C, 32'h0,        32'h11223344, 0, 0, 4'hF, 32'h0,        32'h11223344);
        vecs[13] = mk(0, 1, 0, 3'd6, 32'h010, 32'hA5A50F0F, 32'h0,        1, 0, 4'hF, 32'hA5A50F0F, 32'h0);

        reset = 1'b1; ld = 0; st = 0; rw = 0; wbsel = 0;
        addr = 0; wdata = 0; inst = NOP; pc = 0;
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            vecs[i].t.pc = 32'h1000 + 32'(i * 4);
            run(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Reset lands while an access is stuck in WAIT, with an ack in the same cycle.
        ld = 1; st = 0; rw = 1; inst = {17'h0, 3'd2, 12'h2A3}; addr = 32'h400; pc = 32'h2000;
        dbus_if.ack = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_wait", "stall before reset", 32'(stall), 32'h1);
        reset = 1'b1; dbus_if.ack = 1'b1; dbus_if.rdata = 32'h12345678;
        ld = 0; rw = 0; inst = NOP; addr = 0; pc = 0;
        @(posedge clk); #1;
        reset = 1'b0; dbus_if.ack = 1'b0;
        #1;
        chk_reset_state("rst_wait");

        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            t.ld    = r[0] | r[1];
            t.st    = r[1] & ~r[0] | (r[0] & r[1] & r[2]);
            t.rw    = r[3];
            t.wbsel = r[5:4];
            t.dly   = int'($urandom_range(0, 6));
            t.inst  = $urandom;
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.pc    = $urandom;
            run(t, model(t), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
